// File: rtl/cmd_decoder.sv
// Byte-stream command decoder: assembles 3-byte frames from the UART receive
// stream, maintains shadow/active oscillator phase offsets, drives the reload
// strobe and returns response bytes to the UART transmitter.
// Optional build macro: CMD_TIMEOUT_EN adds an inter-byte timeout that drops a
// partial frame and answers 0xFC.
module cmd_decoder #(
    parameter int unsigned OUTPUTS      = 16,
    parameter int unsigned OFFSET_WIDTH = 24,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned TIMEOUT      = 50000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           rx_data,
    input  logic                            rx_valid,
    output logic                            rx_ready,
    output logic [DATA_WIDTH-1:0]           tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic [OUTPUTS*OFFSET_WIDTH-1:0] offsets,
    output logic                            reload,
    output logic                            busy
);

    localparam int unsigned ChW = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

    localparam logic [2:0] OpNop   = 3'd0;
    localparam logic [2:0] OpWrite = 3'd1;
    localparam logic [2:0] OpApply = 3'd2;
    localparam logic [2:0] OpRead  = 3'd3;

    // Channel field is 4 bits and READ returns value bits [13:0].
    if (OUTPUTS < 2 || OUTPUTS > 16 || OFFSET_WIDTH < 14 || DATA_WIDTH < 8 || TIMEOUT < 2)
    begin : g_param_check
        $error("cmd_decoder: unsupported parameter set");
    end

    typedef enum logic [2:0] {StIdle, StArg1, StArg2, StExec, StResp} state_t;

    state_t                    state_q, state_d;
    logic [7:0]                h_q, h_d;
    logic [6:0]                d1_q, d1_d;
    logic [1:0]                resp_left_q, resp_left_d;
    logic [DATA_WIDTH-1:0]     tx_data_q, tx_data_d;
    logic                      tx_valid_q, tx_valid_d;
    logic                      rx_ready_q, rx_ready_d;
    logic                      reload_q, reload_d;
    logic [OFFSET_WIDTH-1:0]   shadow_q [OUTPUTS];
    logic [OFFSET_WIDTH-1:0]   shadow_d [OUTPUTS];
    logic [OFFSET_WIDTH-1:0]   active_q [OUTPUTS];
    logic [OFFSET_WIDTH-1:0]   active_d [OUTPUTS];
`ifdef CMD_TIMEOUT_EN
    logic [31:0]               tmo_q, tmo_d;
`endif

    logic [7:0]              rx_byte;
    logic                    rx_fire, tx_fire;
    logic [2:0]              opcode;
    logic [3:0]              ch;
    logic                    ch_ok;
    logic [ChW-1:0]          ch_idx;
    logic [OFFSET_WIDTH-1:0] value;
    logic [OFFSET_WIDTH-1:0] shadow_word;

    assign rx_byte     = rx_data[7:0];
    assign rx_fire     = rx_valid & rx_ready_q;
    assign tx_fire     = tx_valid_q & tx_ready;
    assign opcode      = h_q[6:4];
    assign ch          = h_q[3:0];
    assign ch_ok       = (32'(ch) < OUTPUTS);
    assign ch_idx      = ch[ChW-1:0];
    // D2 is consumed straight from the bus on the edge that enters EXEC.
    assign value       = OFFSET_WIDTH'({d1_q, rx_byte[6:0]});
    assign shadow_word = shadow_q[ch_idx];

    // Next-state, register update and response sequencing.
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        d1_d        = d1_q;
        resp_left_d = resp_left_q;
        tx_data_d   = tx_data_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
`ifdef CMD_TIMEOUT_EN
        tmo_d       = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (rx_fire && rx_byte[7]) begin
                    h_d     = rx_byte;
                    state_d = StArg1;
                end
            end
            StArg1: begin
                if (rx_fire) begin
                    if (rx_byte[7]) begin
                        h_d = rx_byte;
                    end else begin
                        d1_d    = rx_byte[6:0];
                        state_d = StArg2;
                    end
                end
            end
            StArg2: begin
                if (rx_fire) begin
                    if (rx_byte[7]) begin
                        h_d     = rx_byte;
                        state_d = StArg1;
                    end else begin
                        // Updates land on entry so they are visible during EXEC.
                        state_d = StExec;
                        if (opcode == OpWrite && ch_ok) shadow_d[ch_idx] = value;
                        if (opcode == OpApply) active_d = shadow_q;
                    end
                end
            end
            StExec: begin
                state_d     = StResp;
                resp_left_d = 2'd0;
                tx_data_d   = DATA_WIDTH'(h_q);
                if (opcode[2]) begin
                    tx_data_d = DATA_WIDTH'(8'hFD);
                end else if ((opcode == OpWrite || opcode == OpRead) && !ch_ok) begin
                    tx_data_d = DATA_WIDTH'(8'hFE);
                end else if (opcode == OpRead) begin
                    resp_left_d = 2'd2;
                end
            end
            StResp: begin
                if (tx_fire) begin
                    if (resp_left_q == 2'd2) begin
                        tx_data_d   = DATA_WIDTH'({1'b0, shadow_word[13:7]});
                        resp_left_d = 2'd1;
                    end else if (resp_left_q == 2'd1) begin
                        tx_data_d   = DATA_WIDTH'({1'b0, shadow_word[6:0]});
                        resp_left_d = 2'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef CMD_TIMEOUT_EN
        if ((state_q == StArg1 || state_q == StArg2) && !rx_fire) begin
            if (tmo_q == TIMEOUT - 1) begin
                state_d     = StResp;
                tx_data_d   = DATA_WIDTH'(8'hFC);
                resp_left_d = 2'd0;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
`endif
        // Handshake/strobe outputs are registered from the next state.
        rx_ready_d = (state_d == StIdle) || (state_d == StArg1) || (state_d == StArg2);
        tx_valid_d = (state_d == StResp);
        reload_d   = !(state_d == StExec && h_d[6:4] == OpApply);
    end

    // State and register bank; reset restores the default i*10 offsets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            h_q         <= '0;
            d1_q        <= '0;
            resp_left_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            rx_ready_q  <= 1'b0;
            reload_q    <= 1'b0;
            for (int i = 0; i < int'(OUTPUTS); i++) begin
                shadow_q[i] <= OFFSET_WIDTH'(i * 10);
                active_q[i] <= OFFSET_WIDTH'(i * 10);
            end
`ifdef CMD_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            d1_q        <= d1_d;
            resp_left_q <= resp_left_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            rx_ready_q  <= rx_ready_d;
            reload_q    <= reload_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
`ifdef CMD_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    for (genvar i = 0; i < int'(OUTPUTS); i++) begin : g_offsets
        assign offsets[OFFSET_WIDTH*i +: OFFSET_WIDTH] = active_q[i];
    end

    assign rx_ready = rx_ready_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign reload   = reload_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder. A second instance with OUTPUTS=8 shares the
// stimulus so the out-of-range channel reply can be observed.
module tb_cmd_decoder;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           rx_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [16*24-1:0] offsets;
    logic           reload;
    logic           busy;

    logic           rx_ready8;
    logic [7:0]     tx_data8;
    logic           tx_valid8;
    logic [8*24-1:0] offsets8;
    logic           reload8;
    logic           busy8;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    cmd_decoder #(.OUTPUTS(16), .OFFSET_WIDTH(24), .DATA_WIDTH(8), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .offsets(offsets),
        .reload(reload), .busy(busy)
    );

    cmd_decoder #(.OUTPUTS(8), .OFFSET_WIDTH(24), .DATA_WIDTH(8), .TIMEOUT(100)) dut8 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready8),
        .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready), .offsets(offsets8),
        .reload(reload8), .busy(busy8)
    );

    function automatic logic [23:0] off16(input int i);
        return offsets[24*i +: 24];
    endfunction

    function automatic logic [23:0] off8(input int i);
        return offsets8[24*i +: 24];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            tick();
            n++;
        end
        if (!rx_ready) begin
            chk_cnt++;
            $display("FAIL rx_handshake_timeout byte=%h rx_ready=%b want 1", b, rx_ready);
        end
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] h, input logic [7:0] a, input logic [7:0] c);
        send_byte(h);
        send_byte(a);
        send_byte(c);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n = 0;
        tx_ready = 1'b1;
        while (!tx_valid && n < 200) begin
            tick();
            n++;
        end
        if (!tx_valid) begin
            chk_cnt++;
            $display("FAIL tx_handshake_timeout tx_valid=%b want 1", tx_valid);
            b = 8'hxx;
        end else begin
            b = tx_data;
        end
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0; rx_data = 8'h00;
        repeat (2) tick();
        chk_cnt++; if (reload !== 1'b0) $display("FAIL rst_reload got %b want 0", reload); else pass_cnt++;
        chk_cnt++; if (rx_ready !== 1'b0) $display("FAIL rst_rx_ready got %b want 0", rx_ready); else pass_cnt++;
        chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid got %b want 0", tx_valid); else pass_cnt++;
        chk_cnt++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data got %h want 00", tx_data); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (off16(0) !== 24'd0) $display("FAIL rst_off0 got %0d want 0", off16(0)); else pass_cnt++;
        chk_cnt++; if (off16(3) !== 24'd30) $display("FAIL rst_off3 got %0d want 30", off16(3)); else pass_cnt++;
        chk_cnt++; if (off16(15) !== 24'd150) $display("FAIL rst_off15 got %0d want 150", off16(15)); else pass_cnt++;
        rst = 1'b0;
        tick();
        chk_cnt++; if (reload !== 1'b1) $display("FAIL rel_reload got %b want 1", reload); else pass_cnt++;
        chk_cnt++; if (rx_ready !== 1'b1) $display("FAIL rel_rx_ready got %b want 1", rx_ready); else pass_cnt++;
        chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL rel_tx_valid got %b want 0", tx_valid); else pass_cnt++;
    endtask

    task automatic test_write();
        logic [7:0] b;
        send_cmd(8'h93, 8'h02, 8'h2C);
        chk_cnt++; if (rx_ready !== 1'b0) $display("FAIL wr_exec_rx_ready got %b want 0", rx_ready); else pass_cnt++;
        chk_cnt++; if (reload !== 1'b1) $display("FAIL wr_exec_reload got %b want 1", reload); else pass_cnt++;
        chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL wr_exec_tx_valid got %b want 0", tx_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (tx_valid !== 1'b1) $display("FAIL wr_resp_tx_valid got %b want 1", tx_valid); else pass_cnt++;
        chk_cnt++; if (off16(3) !== 24'd30) $display("FAIL wr_off3 got %0d want 30", off16(3)); else pass_cnt++;
        chk_cnt++; if (reload !== 1'b1) $display("FAIL wr_resp_reload got %b want 1", reload); else pass_cnt++;
        recv_byte(b);
        chk_cnt++; if (b !== 8'h93) $display("FAIL wr_reply got %h want 93", b); else pass_cnt++;
        chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL wr_done_tx_valid got %b want 0", tx_valid); else pass_cnt++;
        chk_cnt++; if (rx_ready !== 1'b1) $display("FAIL wr_done_rx_ready got %b want 1", rx_ready); else pass_cnt++;
    endtask

    task automatic test_apply();
        logic [7:0] b;
        send_cmd(8'hA0, 8'h00, 8'h00);
        chk_cnt++; if (reload !== 1'b0) $display("FAIL ap_exec_reload got %b want 0", reload); else pass_cnt++;
        chk_cnt++; if (off16(3) !== 24'd300) $display("FAIL ap_exec_off3 got %0d want 300", off16(3)); else pass_cnt++;
        chk_cnt++; if (off16(15) !== 24'd150) $display("FAIL ap_exec_off15 got %0d want 150", off16(15)); else pass_cnt++;
        tick();
        chk_cnt++; if (reload !== 1'b1) $display("FAIL ap_resp_reload got %b want 1", reload); else pass_cnt++;
        chk_cnt++; if (off16(3) !== 24'd300) $display("FAIL ap_resp_off3 got %0d want 300", off16(3)); else pass_cnt++;
        recv_byte(b);
        chk_cnt++; if (b !== 8'hA0) $display("FAIL ap_reply got %h want A0", b); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        send_cmd(8'hB3, 8'h00, 8'h00);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_cnt++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hB3 || rx_ready !== 1'b0)
                $display("FAIL rd_hold%0d got v=%b d=%h rr=%b want 1 B3 0", i, tx_valid, tx_data, rx_ready);
            else pass_cnt++;
            tick();
        end
        tx_ready = 1'b1;
        tick();
        chk_cnt++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h02 || rx_ready !== 1'b0)
            $display("FAIL rd_byte2 got v=%b d=%h rr=%b want 1 02 0", tx_valid, tx_data, rx_ready);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h2C || rx_ready !== 1'b0)
            $display("FAIL rd_byte3 got v=%b d=%h rr=%b want 1 2C 0", tx_valid, tx_data, rx_ready);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1)
            $display("FAIL rd_done got v=%b rr=%b want 0 1", tx_valid, rx_ready);
        else pass_cnt++;
        tx_ready = 1'b0;
    endtask

    task automatic test_resync();
        logic [7:0] b0, b1, b2;
        send_byte(8'h95);
        send_cmd(8'h91, 8'h01, 8'h05);
        recv_byte(b0);
        chk_cnt++; if (b0 !== 8'h91) $display("FAIL rs_a1_reply got %h want 91", b0); else pass_cnt++;
        send_byte(8'h1F);
        tick();
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rs_stray_busy got %b want 0", busy); else pass_cnt++;
        send_cmd(8'hC0, 8'h00, 8'h00);
        recv_byte(b0);
        chk_cnt++; if (b0 !== 8'hFD) $display("FAIL rs_badop got %h want FD", b0); else pass_cnt++;
        send_cmd(8'h92, 8'h7F, 8'h94);
        send_byte(8'h00);
        send_byte(8'h07);
        recv_byte(b0);
        chk_cnt++; if (b0 !== 8'h94) $display("FAIL rs_a2_reply got %h want 94", b0); else pass_cnt++;
        send_cmd(8'hB1, 8'h00, 8'h00);
        recv_byte(b0); recv_byte(b1); recv_byte(b2);
        chk_cnt++;
        if ({b0, b1, b2} !== 24'hB1_01_05) $display("FAIL rs_read1 got %h%h%h want B10105", b0, b1, b2);
        else pass_cnt++;
        send_cmd(8'hB4, 8'h00, 8'h00);
        recv_byte(b0); recv_byte(b1); recv_byte(b2);
        chk_cnt++;
        if ({b0, b1, b2} !== 24'hB4_00_07) $display("FAIL rs_read4 got %h%h%h want B40007", b0, b1, b2);
        else pass_cnt++;
        send_cmd(8'hB2, 8'h00, 8'h00);
        recv_byte(b0); recv_byte(b1); recv_byte(b2);
        chk_cnt++;
        if ({b0, b1, b2} !== 24'hB2_00_14) $display("FAIL rs_read2 got %h%h%h want B20014", b0, b1, b2);
        else pass_cnt++;
    endtask

    task automatic test_bad_channel();
        logic [7:0] b;
        send_cmd(8'h9A, 8'h01, 8'h01);
        tick();
        chk_cnt++; if (tx_data !== 8'h9A) $display("FAIL bc_reply16 got %h want 9A", tx_data); else pass_cnt++;
        chk_cnt++;
        if (tx_valid8 !== 1'b1 || tx_data8 !== 8'hFE)
            $display("FAIL bc_reply8 got v=%b d=%h want 1 FE", tx_valid8, tx_data8);
        else pass_cnt++;
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk_cnt++; if (tx_valid8 !== 1'b0) $display("FAIL bc_done8 got %b want 0", tx_valid8); else pass_cnt++;
        send_cmd(8'hA0, 8'h00, 8'h00);
        recv_byte(b);
        chk_cnt++; if (off16(10) !== 24'd129) $display("FAIL bc_off10 got %0d want 129", off16(10)); else pass_cnt++;
        chk_cnt++; if (off8(2) !== 24'd20) $display("FAIL bc_off8_2 got %0d want 20", off8(2)); else pass_cnt++;
        chk_cnt++; if (off8(3) !== 24'd300) $display("FAIL bc_off8_3 got %0d want 300", off8(3)); else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic [7:0] b0, b1, b2;
`ifdef CMD_TIMEOUT_EN
        send_byte(8'h93);
        send_byte(8'h05);
        repeat (50) tick();
        chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL to_early got %b want 0", tx_valid); else pass_cnt++;
        recv_byte(b0);
        chk_cnt++; if (b0 !== 8'hFC) $display("FAIL to_reply got %h want FC", b0); else pass_cnt++;
        chk_cnt++; if (rx_ready !== 1'b1) $display("FAIL to_rx_ready got %b want 1", rx_ready); else pass_cnt++;
        send_cmd(8'hB3, 8'h00, 8'h00);
        recv_byte(b0); recv_byte(b1); recv_byte(b2);
        chk_cnt++;
        if ({b0, b1, b2} !== 24'hB3_02_2C) $display("FAIL to_read3 got %h%h%h want B3022C", b0, b1, b2);
        else pass_cnt++;
`else
        send_byte(8'h93);
        send_byte(8'h05);
        repeat (150) tick();
        chk_cnt++;
        if (tx_valid !== 1'b0 || busy !== 1'b1 || rx_ready !== 1'b1)
            $display("FAIL nt_wait got v=%b busy=%b rr=%b want 0 1 1", tx_valid, busy, rx_ready);
        else pass_cnt++;
        send_byte(8'h2C);
        recv_byte(b0);
        chk_cnt++; if (b0 !== 8'h93) $display("FAIL nt_reply got %h want 93", b0); else pass_cnt++;
        send_cmd(8'hB3, 8'h00, 8'h00);
        recv_byte(b0); recv_byte(b1); recv_byte(b2);
        chk_cnt++;
        if ({b0, b1, b2} !== 24'hB3_05_2C) $display("FAIL nt_read3 got %h%h%h want B3052C", b0, b1, b2);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] b0, b1, b2;
        send_cmd(8'hB3, 8'h00, 8'h00);
        tick();
        rst = 1'b1;
        #1;
        chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL mr_tx_valid got %b want 0", tx_valid); else pass_cnt++;
        chk_cnt++; if (off16(3) !== 24'd30) $display("FAIL mr_off3 got %0d want 30", off16(3)); else pass_cnt++;
        tick();
        rst = 1'b0;
        tick();
        send_cmd(8'hB3, 8'h00, 8'h00);
        recv_byte(b0); recv_byte(b1); recv_byte(b2);
        chk_cnt++;
        if ({b0, b1, b2} !== 24'hB3_00_1E) $display("FAIL mr_read3 got %h%h%h want B3001E", b0, b1, b2);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_apply();
        test_back_to_back();
        test_resync();
        test_bad_channel();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
